// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host transmit path.
`default_nettype none

package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        SETUP     = 3'd2,
        SHIFT     = 3'd3,
        ACK       = 3'd4,
        WAIT_IDLE = 3'd5
    } ps2_tx_state_t;

    localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
    localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;

    localparam int PS2_FILTER_LEN_DEFAULT = 8;

    // PS/2 frames carry odd parity over the eight data bits.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser, N-sample stability filter and falling-edge pulse for one PS/2 line.
`default_nettype none

module ps2_line_filter
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = PS2_FILTER_LEN_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line_i,
    output logic level_o,
    output logic fall_o
);

    localparam int CW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;

    logic [1:0]    sync_q;
    logic          level_q;
    logic          fall_q;
    logic [CW-1:0] cnt_q;

    // Idle PS/2 lines float high, so the filter powers up believing the line is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b11;
            level_q <= 1'b1;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q <= {sync_q[0], line_i};
            fall_q <= 1'b0;
            if (sync_q[1] == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
                level_q <= sync_q[1];
                fall_q  <= ~sync_q[1];
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign level_o = level_q;
    assign fall_o  = fall_q;

endmodule

`default_nettype wire

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter with ACK check and timeout.
// Define PS2_HOST_TX_RETRY_EN to retransmit a failed byte up to two more times.
`default_nettype none

module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int SETUP_CYCLES   = 250,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int FILTER_LEN     = PS2_FILTER_LEN_DEFAULT
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       done,
    output logic       error,
    output logic       busy,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    localparam int MAX_A   = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
    localparam int MAX_CNT = (TIMEOUT_CYCLES > MAX_A) ? TIMEOUT_CYCLES : MAX_A;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    ps2_tx_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_q, bit_d;
    logic [10:0]      shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             par_q, par_d;
`ifdef PS2_HOST_TX_RETRY_EN
    logic [1:0]       retry_q, retry_d;
`endif

    logic clk_level, clk_fall;
    logic dat_level, dat_fall_unused;
    logic timeout, fail;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk     (CLOCK_50),
        .rst_n   (reset),
        .line_i  (ps2_clk_in),
        .level_o (clk_level),
        .fall_o  (clk_fall)
    );

    // Only the data level matters here; data-line edges carry no meaning for the host.
    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filter (
        .clk     (CLOCK_50),
        .rst_n   (reset),
        .line_i  (ps2_dat_in),
        .level_o (dat_level),
        .fall_o  (dat_fall_unused)
    );

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= 4'd0;
            shift_q <= '1;
            data_q  <= 8'h00;
            par_q   <= 1'b1;
`ifdef PS2_HOST_TX_RETRY_EN
            retry_q <= 2'd0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            par_q   <= par_d;
`ifdef PS2_HOST_TX_RETRY_EN
            retry_q <= retry_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        data_d     = data_q;
        par_d      = par_q;
`ifdef PS2_HOST_TX_RETRY_EN
        retry_d    = retry_q;
`endif
        fail       = 1'b0;
        tx_ready   = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        ps2_clk_oe = 1'b0;
        ps2_dat_oe = 1'b0;
        busy       = (state_q != IDLE);
        timeout    = ((state_q == SHIFT) || (state_q == ACK) || (state_q == WAIT_IDLE)) &&
                     (cnt_q == CNT_W'(TIMEOUT_CYCLES));

        case (state_q)
            IDLE: begin
                tx_ready = 1'b1;
                if (tx_valid) begin
                    data_d  = tx_data;
                    par_d   = odd_parity(tx_data);
                    cnt_d   = '0;
                    state_d = INHIBIT;
`ifdef PS2_HOST_TX_RETRY_EN
                    retry_d = 2'd0;
`endif
                end
            end
            INHIBIT: begin
                ps2_clk_oe = 1'b1;
                shift_d    = {1'b1, par_q, data_q, 1'b0};
                bit_d      = 4'd0;
                if (cnt_q == CNT_W'(INHIBIT_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = SETUP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SETUP: begin
                ps2_clk_oe = 1'b1;
                ps2_dat_oe = 1'b1;
                if (cnt_q == CNT_W'(SETUP_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = SHIFT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SHIFT: begin
                cnt_d = cnt_q + 1'b1;
                // shift_q[0] holds the bit for the current index; the start bit sits there first.
                if (timeout) begin
                    fail = 1'b1;
                end else begin
                    ps2_dat_oe = ~shift_q[0];
                    if (clk_fall) begin
                        shift_d = {1'b1, shift_q[10:1]};
                        bit_d   = bit_q + 4'd1;
                        if (bit_q == 4'd9) begin
                            state_d = ACK;
                        end
                    end
                end
            end
            ACK: begin
                cnt_d = cnt_q + 1'b1;
                if (timeout) begin
                    fail = 1'b1;
                end else if (clk_fall) begin
                    if (dat_level) begin
                        fail = 1'b1;
                    end else begin
                        state_d = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                cnt_d = cnt_q + 1'b1;
                if (timeout) begin
                    fail = 1'b1;
                end else if (clk_level && dat_level) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (fail) begin
`ifdef PS2_HOST_TX_RETRY_EN
            if (retry_q != 2'd2) begin
                retry_d = retry_q + 2'd1;
                cnt_d   = '0;
                state_d = INHIBIT;
            end else begin
                error   = 1'b1;
                state_d = IDLE;
            end
`else
            error   = 1'b1;
            state_d = IDLE;
`endif
        end
    end

endmodule

`default_nettype wire

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter for the keyboard port on `CLOCK_50`. It sends one command byte per request to the keyboard, such as LED set `8'hED`, reset `8'hFF` or enable `8'hF4`. It drives the PS/2 clock and data lines through open-drain enables, while the device clocks out the frame. It also checks the device acknowledge bit. `busy` tells the existing keyboard receive path to ignore line activity while a transmit is in progress.

## Interface
- `INHIBIT_CYCLES`, 5000: cycles the clock line is held low before the request (100 µs at 50 MHz).
- `SETUP_CYCLES`, 250: cycles the data line is held low before the clock line is released.
- `TIMEOUT_CYCLES`, 750000: cycles allowed from clock release to the ACK bit (15 ms).
- `FILTER_LEN`, 8: consecutive equal samples needed to accept a line level.
- `CLOCK_50`, input, 1: system clock.
- `reset`, input, 1: asynchronous, active-low reset.
- `tx_valid`, input, 1: transmit request.
- `tx_data`, input, 8: command byte, captured on handshake.
- `tx_ready`, output, 1: block can accept a byte.
- `done`, output, 1: one-cycle pulse when the device acknowledged the frame.
- `error`, output, 1: one-cycle pulse on NACK or timeout.
- `busy`, output, 1: high in every state except IDLE.
- `ps2_clk_in`, input, 1: raw PS/2 clock line level.
- `ps2_dat_in`, input, 1: raw PS/2 data line level.
- `ps2_clk_oe`, output, 1: 1 pulls the clock line low.
- `ps2_dat_oe`, output, 1: 1 pulls the data line low.

## Operation
- **Handshake:** a transfer occurs when `tx_valid & tx_ready`. `tx_data` is latched and odd parity is computed at that point. `tx_ready` is high only in IDLE.
- **IDLE:** both line enables are 0.
- **INHIBIT:** `ps2_clk_oe` = 1 for exactly `INHIBIT_CYCLES` cycles.
- **SETUP:** `ps2_clk_oe` = 1 and `ps2_dat_oe` = 1 (start bit) for `SETUP_CYCLES` cycles.
- **SHIFT:**
  - `ps2_clk_oe` = 0; the timeout counter starts.
  - Bit index starts at 0 and advances on each filtered falling edge of the PS/2 clock.
  - Edges 1–8 drive `tx_data[0..7]`, LSB first.
  - Edge 9 drives the parity bit.
  - Edge 10 releases data (stop bit = 1).
  - A data bit of value b is driven as `ps2_dat_oe` = ~b.
- **ACK:** filtered data is sampled on the 11th falling edge.
  - Low: go to WAIT_IDLE.
  - High: `error` pulse, then IDLE.
- **WAIT_IDLE:** waits until filtered clock and data are both high, then pulses `done` and returns to IDLE.
- **Timeout:** if the timeout counter reaches `TIMEOUT_CYCLES` in SHIFT, ACK or WAIT_IDLE:
  - both enables are released;
  - `error` pulses;
  - the block returns to IDLE.
- **Line filter:** each input passes through a 2-flop synchroniser, then a `FILTER_LEN`-sample stability filter.
  - A falling edge is a filtered 1→0 transition.
  - Edges seen in IDLE, INHIBIT or SETUP are ignored.
- **Reset:** all outputs take their reset values immediately, including mid-frame, so the lines are released asynchronously.
  - Reset values: `ps2_clk_oe` = 0, `ps2_dat_oe` = 0, `tx_ready` = 1, `busy` = 0, `done` = 0, `error` = 0.
  - The state returns to IDLE.
- **Simultaneous events:** a timeout in the same cycle as the ACK edge resolves as a timeout. `tx_valid` outside IDLE is ignored; no request is queued.

## Timing
- Handshake cycle to `ps2_clk_oe` rising: 1 cycle.
- INHIBIT, then SETUP, with no gap between them.
- Falling-edge detect latency: 2 + `FILTER_LEN` cycles after the raw edge.
- A data bit changes 1 cycle after its edge is detected.
- `done` and `error` are mutually exclusive, at most one pulse per transfer.
- `tx_ready` reasserts in the cycle after the pulse.

## Configuration
- **`PS2_HOST_TX_RETRY_EN` defined:**
  - On NACK or timeout, the latched byte is retransmitted from INHIBIT, up to 2 retries.
  - `error` pulses only after the final failure.
  - `busy` stays high throughout the retries.
- **Not defined:** the first failure pulses `error`; no retry logic is compiled.

## Structure
- **Package `ps2_pkg`:**
  - state enum `ps2_tx_state_t`: IDLE, INHIBIT, SETUP, SHIFT, ACK, WAIT_IDLE;
  - command constants `PS2_CMD_SET_LED` = 8'hED, `PS2_CMD_RESET` = 8'hFF, `PS2_CMD_ENABLE` = 8'hF4;
  - default filter length.
- **Sub-module `ps2_line_filter`:** synchroniser, stability filter and falling-edge detect. It has two instances, one for clock and one for data.

## Test plan
- **Send `8'hED`:** the device model clocks 11 edges and pulls data low at the 11th.
  - Bits driven: `1,0,1,1,0,1,1,1`, parity 1, stop released.
  - `done` pulses once; `error` stays 0.
- **Send `8'hF4`:** parity bit = 0; `ps2_clk_oe` is high for exactly 5000 cycles, then SETUP lasts 250 cycles.
- **NACK:** data is high at the 11th edge, so `error` pulses and `tx_ready` returns to 1. With `PS2_HOST_TX_RETRY_EN`, 3 full frames are seen before `error`.
- **Timeout:** the device model never clocks, so `error` pulses 750000 cycles after clock release and both enables are 0.
- **Reset mid-frame:** assert `reset` low after edge 5. Both enables drop to 0 the same cycle and `tx_ready` is 1 on release.
- **Glitch rejection:** a 3-cycle low pulse on `ps2_clk_in` during SHIFT does not advance the bit index.
